// File: rtl/ordered_response_router.sv
// Issues arbitrated requests to an in-order memory side and routes each returning response
// back to the requester recorded, oldest first, in a small source-index tracker FIFO.
module ordered_response_router #(
  parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS  = 64,
  parameter int unsigned SINGLE_RESPONSE_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_REQUEST                   = 3,
  parameter int unsigned NUM_REQUEST_LOG2              = $clog2(NUM_REQUEST) + 1,
  parameter int unsigned MAX_OUTSTANDING               = 4
) (
  input  logic                                                 reset_in,
  input  logic                                                 clk_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]              request_in,
  input  logic [NUM_REQUEST_LOG2-1:0]                          request_source_in,
  input  logic                                                 request_valid_in,
  output logic                                                 issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]              request_out,
  output logic                                                 request_valid_out,
  input  logic                                                 issue_ack_in,
  input  logic [SINGLE_RESPONSE_WIDTH_IN_BITS-1:0]             response_in,
  input  logic                                                 response_valid_in,
  output logic                                                 response_ack_out,
  output logic [SINGLE_RESPONSE_WIDTH_IN_BITS*NUM_REQUEST-1:0] response_flatted_out,
  output logic [NUM_REQUEST-1:0]                               response_valid_flatted_out,
  input  logic [NUM_REQUEST-1:0]                               response_ack_flatted_in,
  output logic                                                 unexpected_response_out
);

  localparam int unsigned QW   = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int unsigned RW   = SINGLE_RESPONSE_WIDTH_IN_BITS;
  localparam int unsigned SW   = NUM_REQUEST_LOG2;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [QW-1:0]   req_q, req_d;
  logic            req_valid_q, req_valid_d;
  logic [RW-1:0]   resp_q, resp_d;
  logic            resp_valid_q, resp_valid_d;
  logic [SW-1:0]   dest_q, dest_d;
  logic [SW-1:0]   src_mem_q [MAX_OUTSTANDING];
  logic [SW-1:0]   src_mem_d [MAX_OUTSTANDING];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            unexpected_q, unexpected_d;

  logic            push, pop, ack_slot, tracker_empty;
  logic [SW-1:0]   head_src;

  assign tracker_empty = (count_q == '0);
  assign head_src      = src_mem_q[head_q];

  // Steer the held response to its destination slot and pick up that slot's consume.
  always_comb begin
    response_flatted_out       = '0;
    response_valid_flatted_out = '0;
    ack_slot                   = 1'b0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (dest_q == SW'(i)) begin
        response_flatted_out[i*RW +: RW] = resp_q;
        response_valid_flatted_out[i]    = resp_valid_q;
        ack_slot                         = response_ack_flatted_in[i];
      end
    end
  end

  // An empty tracker still acks responses so a stray one is dropped rather than stalling.
  assign issue_ack_out    = (count_q < CntW'(MAX_OUTSTANDING)) & (~req_valid_q | issue_ack_in);
  assign response_ack_out = tracker_empty | ~resp_valid_q | ack_slot;

  assign push = request_valid_in & issue_ack_out;
  assign pop  = response_valid_in & response_ack_out & ~tracker_empty;

  always_comb begin
    req_d        = req_q;
    req_valid_d  = req_valid_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    dest_d       = dest_q;
    src_mem_d    = src_mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    unexpected_d = unexpected_q;

    if (push) begin
      req_d             = request_in;
      req_valid_d       = 1'b1;
      src_mem_d[tail_q] = request_source_in;
      tail_d            = (tail_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + 1'b1;
    end else if (req_valid_q & issue_ack_in) begin
      req_d       = '0;
      req_valid_d = 1'b0;
    end

    if (pop) begin
      // Out-of-range sources are popped but never presented on any slot.
      dest_d       = head_src;
      resp_valid_d = (head_src < SW'(NUM_REQUEST));
      resp_d       = (head_src < SW'(NUM_REQUEST)) ? response_in : '0;
      head_d       = (head_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : head_q + 1'b1;
    end else if (resp_valid_q & ack_slot) begin
      resp_d       = '0;
      resp_valid_d = 1'b0;
    end

    if (response_valid_in & tracker_empty) begin
      unexpected_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      dest_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      unexpected_q <= 1'b0;
    end else begin
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      dest_q       <= dest_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      unexpected_q <= unexpected_d;
    end
  end

  // Tracker storage needs no reset: only entries between head and tail are ever read.
  always_ff @(posedge clk_in) begin
    src_mem_q <= src_mem_d;
  end

  assign request_out             = req_q;
  assign request_valid_out       = req_valid_q;
  assign unexpected_response_out = unexpected_q;

endmodule

// File: tb/tb_ordered_response_router.sv
// Directed and randomized checks of ordered_response_router against a queue-based model.
module tb_ordered_response_router;

  localparam int NR   = 3;
  localparam int MAXO = 4;
  localparam int W    = 64;

  logic            reset_in, clk_in;
  logic [W-1:0]    request_in;
  logic [2:0]      request_source_in;
  logic            request_valid_in, issue_ack_out;
  logic [W-1:0]    request_out;
  logic            request_valid_out, issue_ack_in;
  logic [W-1:0]    response_in;
  logic            response_valid_in, response_ack_out;
  logic [W*NR-1:0] response_flatted_out;
  logic [NR-1:0]   response_valid_flatted_out, response_ack_flatted_in;
  logic            unexpected_response_out;

  ordered_response_router dut (
    .reset_in                  (reset_in),
    .clk_in                    (clk_in),
    .request_in                (request_in),
    .request_source_in         (request_source_in),
    .request_valid_in          (request_valid_in),
    .issue_ack_out             (issue_ack_out),
    .request_out               (request_out),
    .request_valid_out         (request_valid_out),
    .issue_ack_in              (issue_ack_in),
    .response_in               (response_in),
    .response_valid_in         (response_valid_in),
    .response_ack_out          (response_ack_out),
    .response_flatted_out      (response_flatted_out),
    .response_valid_flatted_out(response_valid_flatted_out),
    .response_ack_flatted_in   (response_ack_flatted_in),
    .unexpected_response_out   (unexpected_response_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state: outstanding sources in issue order plus the two output registers.
  int           mq[$];
  logic [W-1:0] m_req, m_rsp;
  logic         m_req_v, m_rsp_v, m_unexp;
  int           m_dest;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req = '0; m_req_v = 1'b0; m_rsp = '0; m_rsp_v = 1'b0; m_dest = 0; m_unexp = 1'b0;
  endtask

  task automatic cyc(input logic rst, input logic rv, input logic [W-1:0] req, input int src,
                     input logic iack, input logic rspv, input logic [W-1:0] rsp,
                     input logic [NR-1:0] rack);
    int              sz, s;
    logic            e_iack, e_rack, slot_ack, popped;
    logic [W*NR-1:0] e_flat;
    logic [NR-1:0]   e_vflat;
    reset_in = rst; request_valid_in = rv; request_in = req; request_source_in = 3'(src);
    issue_ack_in = iack; response_valid_in = rspv; response_in = rsp;
    response_ack_flatted_in = rack;
    #1;
    sz       = mq.size();
    slot_ack = (m_dest < NR) ? rack[m_dest] : 1'b0;
    e_iack   = (sz < MAXO) && (!m_req_v || iack);
    e_rack   = (sz == 0) || !m_rsp_v || slot_ack;
    e_flat   = '0;
    e_vflat  = '0;
    if (m_dest < NR) begin
      e_flat[m_dest*W +: W] = m_rsp;
      e_vflat[m_dest]       = m_rsp_v;
    end
    chk("issue_ack_out", 256'(issue_ack_out), 256'(e_iack));
    chk("response_ack_out", 256'(response_ack_out), 256'(e_rack));
    chk("request_out", 256'(request_out), 256'(m_req));
    chk("request_valid_out", 256'(request_valid_out), 256'(m_req_v));
    chk("response_flatted_out", 256'(response_flatted_out), 256'(e_flat));
    chk("response_valid_flatted_out", 256'(response_valid_flatted_out), 256'(e_vflat));
    chk("unexpected_response_out", 256'(unexpected_response_out), 256'(m_unexp));
    @(posedge clk_in);
    if (rst) model_reset();
    else begin
      popped = 1'b0;
      if (rspv && e_rack) begin
        if (sz == 0) m_unexp = 1'b1;
        else begin
          s = mq.pop_front();
          popped = 1'b1;
          m_dest = s;
          m_rsp_v = (s < NR);
          m_rsp = (s < NR) ? rsp : '0;
        end
      end
      if (!popped && m_rsp_v && slot_ack) begin
        m_rsp = '0; m_rsp_v = 1'b0;
      end
      if (rv && e_iack) begin
        m_req = req; m_req_v = 1'b1; mq.push_back(src);
      end else if (iack && m_req_v) begin
        m_req = '0; m_req_v = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    reset_in = 1'b1; request_valid_in = 1'b0; request_in = '0; request_source_in = '0;
    issue_ack_in = 1'b0; response_valid_in = 1'b0; response_in = '0;
    response_ack_flatted_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 3'b000);

    // Single round trip to source 2.
    cyc(0, 1, 64'h1111, 2, 1, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 64'hA5, 3'b000);
    cyc(0, 0, 0, 0, 1, 0, 0, 3'b000);
    chk("d_slot2_valid", 256'(response_valid_flatted_out), 256'(3'b100));
    chk("d_slot2_data", 256'(response_flatted_out), 256'({64'hA5, 128'h0}));
    cyc(0, 0, 0, 0, 1, 0, 0, 3'b100);

    // Fill the tracker, then hold responses at the output with no consumer.
    cyc(0, 1, 64'h10, 0, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h11, 1, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h12, 2, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h13, 0, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h14, 1, 1, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 64'hB0, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 64'hB1, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 64'hB1, 3'b110);
    cyc(0, 0, 0, 0, 1, 1, 64'hB1, 3'b001);
    cyc(0, 0, 0, 0, 1, 1, 64'hB2, 3'b010);
    cyc(0, 0, 0, 0, 1, 1, 64'hB3, 3'b100);
    cyc(0, 0, 0, 0, 1, 0, 0, 3'b001);

    // Out-of-range source is tracked but never presented.
    cyc(0, 1, 64'h20, 5, 1, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 64'hC0, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 0, 3'b000);
    chk("d_oor_dropped", 256'(response_valid_flatted_out), 256'(3'b000));

    // Stray response with an empty tracker.
    cyc(1, 0, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 0, 1, 64'hDD, 3'b000);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 3'b111);
    chk("d_unexpected_sticky", 256'(unexpected_response_out), 256'(1'b1));

    // Reset with three outstanding and a request still held.
    cyc(1, 0, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 1, 64'h30, 0, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h31, 1, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h32, 2, 1, 0, 0, 3'b000);
    cyc(1, 1, 64'h33, 1, 0, 1, 64'h99, 3'b111);
    chk("d_reset_req_valid", 256'(request_valid_out), 256'(1'b0));
    cyc(0, 0, 0, 0, 0, 1, 64'h77, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 0, 3'b000);

    // Steady push/pop at occupancy 2 so the pointers wrap repeatedly.
    cyc(1, 0, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 1, 64'h40, 1, 1, 0, 0, 3'b000);
    cyc(0, 1, 64'h41, 2, 1, 0, 0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, rnd64(), i % NR, 1, 1, rnd64(), 3'b111);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, rnd64(),
          $urandom_range(0, 4), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
          rnd64(), 3'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
